// File: rtl/energy_pkg.sv
// Shared types and default constants for the energy-manager input path.
package energy_pkg;

   typedef enum logic [1:0] {
      Z_IDLE = 2'd0,
      Z_LOW  = 2'd1,
      Z_HIGH = 2'd2
   } demand_zone_e;

   typedef enum logic {
      HS_ACCEPT = 1'b0,
      HS_EVAL   = 1'b1
   } hs_state_e;

   localparam int DEF_ADC_W          = 12;
   localparam int DEF_LOW_TH         = 2248;
   localparam int DEF_HIGH_TH        = 3400;
   localparam int DEF_HYST           = 64;
   localparam int DEF_STABLE_SAMPLES = 4;
   localparam int DEF_DEB_CYCLES     = 50000;

   // {high, low, idle}; unused encoding decodes to idle so the output stays one-hot
   function automatic logic [2:0] zone_onehot(input demand_zone_e z);
      case (z)
         Z_LOW:   return 3'b010;
         Z_HIGH:  return 3'b100;
         default: return 3'b001;
      endcase
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a hold-time debounce counter.
module btn_debounce #(
   parameter int DEB_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_n,
   output logic level
);

   localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_n;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;

endmodule

// File: rtl/demand_encoder.sv
// Joystick zone classifier with hysteresis and confirmation, plus debounced
// brake / battery buttons feeding the energy manager.
module demand_encoder
   import energy_pkg::*;
#(
   parameter int ADC_W          = DEF_ADC_W,
   parameter int LOW_TH         = DEF_LOW_TH,
   parameter int HIGH_TH        = DEF_HIGH_TH,
   parameter int HYST           = DEF_HYST,
   parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
   parameter int DEB_CYCLES     = DEF_DEB_CYCLES
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             adc_valid,
   output logic             adc_ready,
   input  logic [ADC_W-1:0] adc_data,
   input  logic             btn_a_n,
   input  logic             btn_b_n,
   output logic             p_demand_low,
   output logic             p_demand_high,
   output logic             p_idle,
   output logic             is_braking,
   output logic             battery_button,
   output logic             demand_changed
);

   if (!(LOW_TH >= HYST && HIGH_TH + HYST <= (1 << ADC_W) - 1 &&
         LOW_TH + HYST < HIGH_TH - HYST && STABLE_SAMPLES >= 1 && DEB_CYCLES >= 1)) begin : g_bad_params
      $error("demand_encoder: illegal threshold/hysteresis parameters");
   end

   localparam int CW = (STABLE_SAMPLES < 2) ? 1 : $clog2(STABLE_SAMPLES + 1);
   localparam logic [ADC_W:0] LO_UP = (ADC_W + 1)'(LOW_TH + HYST);
   localparam logic [ADC_W:0] LO_DN = (ADC_W + 1)'(LOW_TH - HYST);
   localparam logic [ADC_W:0] HI_UP = (ADC_W + 1)'(HIGH_TH + HYST);
   localparam logic [ADC_W:0] HI_DN = (ADC_W + 1)'(HIGH_TH - HYST);

   hs_state_e        state_q, state_d;
   logic [ADC_W-1:0] sample_q, sample_d;
   demand_zone_e     zone_q, zone_d;
   demand_zone_e     prev_q, prev_d;
   demand_zone_e     cand;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_nxt;
   logic [2:0]       demand_q;
   logic             changed_q, changed_d;
   logic [ADC_W:0]   s;
   logic             btn_a_lvl;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
      .clk(clk), .reset_n(reset_n), .btn_n(btn_a_n), .level(btn_a_lvl)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
      .clk(clk), .reset_n(reset_n), .btn_n(btn_b_n), .level(battery_button)
   );

   assign is_braking = ~btn_a_lvl;
   assign s          = {1'b0, sample_q};

   // Hysteresis: thresholds to enter a zone sit above those to leave it
   always_comb begin
      cand = zone_q;
      case (zone_q)
         Z_IDLE:  cand = (s >= HI_UP) ? Z_HIGH : (s >= LO_UP) ? Z_LOW : Z_IDLE;
         Z_LOW:   cand = (s >= HI_UP) ? Z_HIGH : (s < LO_DN) ? Z_IDLE : Z_LOW;
         Z_HIGH:  cand = (s < LO_DN) ? Z_IDLE : (s < HI_DN) ? Z_LOW : Z_HIGH;
         default: cand = Z_IDLE;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      sample_d  = sample_q;
      zone_d    = zone_q;
      prev_d    = prev_q;
      cnt_d     = cnt_q;
      cnt_nxt   = '0;
      changed_d = 1'b0;
      case (state_q)
         HS_ACCEPT: begin
            if (adc_valid) begin
               sample_d = adc_data;
               state_d  = HS_EVAL;
            end
         end
         default: begin
            state_d = HS_ACCEPT;
            prev_d  = cand;
            // Brake interlock blocks any upward progress but lets demand fall
            if (cand == zone_q || (is_braking && cand > zone_q)) cnt_nxt = '0;
            else if (cand != prev_q)                              cnt_nxt = CW'(1);
            else                                                  cnt_nxt = cnt_q + 1'b1;
            if (cnt_nxt == CW'(STABLE_SAMPLES)) begin
               zone_d    = cand;
               cnt_d     = '0;
               changed_d = 1'b1;
            end else begin
               cnt_d = cnt_nxt;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= HS_ACCEPT;
         sample_q  <= '0;
         zone_q    <= Z_IDLE;
         prev_q    <= Z_IDLE;
         cnt_q     <= '0;
         demand_q  <= 3'b001;
         changed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sample_q  <= sample_d;
         zone_q    <= zone_d;
         prev_q    <= prev_d;
         cnt_q     <= cnt_d;
         demand_q  <= zone_onehot(zone_d);
         changed_q <= changed_d;
      end
   end

   assign adc_ready      = (state_q == HS_ACCEPT);
   assign p_idle         = demand_q[0];
   assign p_demand_low   = demand_q[1];
   assign p_demand_high  = demand_q[2];
   assign demand_changed = changed_q;

endmodule

// File: tb/tb_demand_encoder.sv
// Directed stimulus with a queue-based scoreboard checking zone and commit pulse per sample.
module tb_demand_encoder;

   localparam int IDLE = 0, LOW = 1, HIGH = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        adc_valid = 1'b0;
   logic        adc_ready;
   logic [11:0] adc_data = '0;
   logic        btn_a_n = 1'b1;
   logic        btn_b_n = 1'b1;
   logic        p_demand_low, p_demand_high, p_idle;
   logic        is_braking, battery_button, demand_changed;

   int n_chk = 0;
   int n_fail = 0;
   int pulses = 0;
   int onehot_err = 0;
   int exp_q[$];

   demand_encoder #(
      .ADC_W(12), .LOW_TH(2248), .HIGH_TH(3400), .HYST(64),
      .STABLE_SAMPLES(4), .DEB_CYCLES(8)
   ) dut (
      .clk(clk), .reset_n(reset_n), .adc_valid(adc_valid), .adc_ready(adc_ready),
      .adc_data(adc_data), .btn_a_n(btn_a_n), .btn_b_n(btn_b_n),
      .p_demand_low(p_demand_low), .p_demand_high(p_demand_high), .p_idle(p_idle),
      .is_braking(is_braking), .battery_button(battery_button),
      .demand_changed(demand_changed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int zone_bits(input int z);
      return (z == HIGH) ? 4 : (z == LOW) ? 2 : 1;
   endfunction

   // Monitor: one check per accepted sample, one edge after acceptance
   initial begin
      forever begin
         @(posedge clk);
         if (reset_n && adc_valid && adc_ready) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
               chk("scoreboard_underflow", 1, 0);
            end else begin
               int e;
               e = exp_q.pop_front();
               chk("zone", {p_demand_high, p_demand_low, p_idle}, zone_bits(e >> 1));
               chk("demand_changed", demand_changed, e & 1);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (demand_changed) pulses++;
      if ((32'(p_idle) + 32'(p_demand_low) + 32'(p_demand_high)) != 1) onehot_err++;
   end

   task automatic send(input int d, input int ez, input int ec, input bit rst_mid);
      int n;
      n = 0;
      @(negedge clk);
      while (!adc_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!adc_ready) begin
         chk("adc_ready_timeout", 0, 1);
         return;
      end
      exp_q.push_back((ez << 1) | ec);
      adc_data  = 12'(d);
      adc_valid = 1'b1;
      @(posedge clk);
      #1 adc_valid = 1'b0;
      if (rst_mid) begin
         reset_n = 1'b0;
         @(posedge clk);
         #3 reset_n = 1'b1;
      end
   endtask

   task automatic send_n(input int d, input int cnt, input int final_z, input int hold_z,
                         input int final_c);
      for (int i = 0; i < cnt; i++)
         send(d, (i == cnt - 1) ? final_z : hold_z, (i == cnt - 1) ? final_c : 0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("rst_p_idle", p_idle, 1);
      chk("rst_p_low", p_demand_low, 0);
      chk("rst_p_high", p_demand_high, 0);
      chk("rst_battery", battery_button, 1);
      chk("rst_braking", is_braking, 0);
      chk("rst_adc_ready", adc_ready, 1);
      chk("rst_pulses", pulses, 0);

      // Battery button press and release
      btn_b_n = 1'b0;
      repeat (12) @(negedge clk);
      chk("battery_pressed", battery_button, 0);
      btn_b_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("battery_released", battery_button, 1);

      send_n(2400, 3, IDLE, IDLE, 0);
      send(2000, IDLE, 0, 1'b0);
      send_n(2400, 4, LOW, IDLE, 1);
      send_n(2200, 10, LOW, LOW, 0);
      send_n(2100, 4, IDLE, LOW, 1);
      send_n(3500, 4, HIGH, IDLE, 1);
      send_n(3300, 4, LOW, HIGH, 1);
      send_n(2000, 4, IDLE, LOW, 1);
      send_n(2400, 4, LOW, IDLE, 1);

      // Short brake glitch must not pass
      @(negedge clk);
      btn_a_n = 1'b0;
      repeat (5) @(negedge clk);
      btn_a_n = 1'b1;
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (is_braking) seen = 1;
      end
      chk("brake_short_press", seen, 0);

      btn_a_n = 1'b0;
      repeat (9) @(posedge clk);
      #1 chk("brake_edge9", is_braking, 0);
      @(posedge clk);
      #1 chk("brake_edge10", is_braking, 1);
      repeat (10) @(posedge clk);

      send_n(3500, 6, LOW, LOW, 0);
      @(negedge clk);
      btn_a_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("brake_released", is_braking, 0);
      send_n(3500, 4, HIGH, LOW, 1);

      send_n(2000, 3, HIGH, HIGH, 0);
      send(2000, IDLE, 0, 1'b1);
      @(negedge clk);
      chk("post_rst_p_idle", p_idle, 1);
      chk("post_rst_battery", battery_button, 1);
      chk("post_rst_braking", is_braking, 0);
      chk("post_rst_adc_ready", adc_ready, 1);
      send(2400, IDLE, 0, 1'b0);

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("commit_pulses", pulses, 7);
      chk("onehot_violations", onehot_err, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
